// File: rtl/impact_array_sequencer_pkg.sv
// Shared FSM state type and width helpers for the IMPACT array sequencer.
package impact_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRECHG = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } seq_state_t;

  // Byte lanes in a data word.
  function automatic int calc_nl(input int data_w);
    return data_w / 8;
  endfunction

  // Select width for n choices, never narrower than one bit.
  function automatic int calc_sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/impact_array_sequencer_phase_timer.sv
// Loadable down-counter for phase timing; done is high while the count is zero.
module impact_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/impact_array_sequencer.sv
// Command-driven precharge/access sequencer for the IMPACT project arrays.
// Optional IMPACT_SEQ_PERF_EN adds saturating read/write response counters.
//
// state     | meaning
// ST_IDLE   | ready for a command (cmd_ready high once out of reset)
// ST_PRECHG | bitline precharge for PRECHG_CYC cycles
// ST_ACCESS | wordline on with read sense or write drive for ACC_CYC cycles
// ST_RESP   | response held on rsp_* until rsp_ready
module impact_array_sequencer
  import impact_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int ADDR_W     = 4,
  parameter  int N_PROJ     = 4,
  parameter  int PRECHG_CYC = 2,
  parameter  int ACC_CYC    = 2,
  localparam int NL         = calc_nl(DATA_W),
  localparam int PSEL_W     = calc_sel_w(N_PROJ),
  localparam int BSEL_W     = calc_sel_w(NL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [PSEL_W-1:0] cmd_proj,
  input  logic              cmd_byte_mode,
  input  logic [BSEL_W-1:0] cmd_byte_sel,
  input  logic              cmd_trunc,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              precharge,
  output logic              wl_en,
  output logic [ADDR_W-1:0] wl_addr,
  output logic              read_en,
  output logic [NL-1:0]     write_en,
  output logic              din_en,
  output logic [PSEL_W-1:0] proj_sel,
  output logic [DATA_W-1:0] array_din,
  input  logic [DATA_W-1:0] array_dout,
  output logic              busy,
  output logic              done_irq
`ifdef IMPACT_SEQ_PERF_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int PH_MAX = (PRECHG_CYC > ACC_CYC) ? PRECHG_CYC : ACC_CYC;
  localparam int CNT_W  = calc_sel_w(PH_MAX);
  localparam logic [CNT_W-1:0] PRECHG_LD = CNT_W'(PRECHG_CYC - 1);
  localparam logic [CNT_W-1:0] ACC_LD    = CNT_W'(ACC_CYC - 1);

  seq_state_t        state;
  logic              armed;
  logic              we_q;
  logic              byte_mode_q;
  logic              trunc_q;
  logic [BSEL_W-1:0] byte_sel_q;
  logic              accept;
  logic              phase_done;
  logic              timer_load;
  logic              timer_en;
  logic [CNT_W-1:0]  timer_val;
  logic [NL-1:0]     lane_mask;
  logic [DATA_W-1:0] shaped;

  // armed keeps cmd_ready low while reset is asserted and until the first clock after release.
  assign cmd_ready  = armed && (state == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign timer_load = accept || ((state == ST_PRECHG) && phase_done);
  assign timer_val  = accept ? PRECHG_LD : ACC_LD;
  assign timer_en   = (state == ST_PRECHG) || (state == ST_ACCESS);

  impact_phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .done     (phase_done)
  );

  // An out-of-range lane select matches no lane, so nothing is written or returned.
  always_comb begin
    lane_mask = '0;
    shaped    = '0;
    if (!byte_mode_q) begin
      lane_mask = '1;
      shaped    = array_dout;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (byte_sel_q == BSEL_W'(i)) begin
          lane_mask[i] = 1'b1;
          shaped[7:0]  = array_dout[i*8 +: 8];
        end
      end
    end
    if (trunc_q) begin
      for (int i = 0; i < NL; i++) begin
        shaped[i*8+4 +: 4] = 4'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      armed       <= 1'b0;
      we_q        <= 1'b0;
      byte_mode_q <= 1'b0;
      byte_sel_q  <= '0;
      trunc_q     <= 1'b0;
      wl_addr     <= '0;
      proj_sel    <= '0;
      array_din   <= '0;
      rsp_rdata   <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q        <= cmd_we;
            byte_mode_q <= cmd_byte_mode;
            byte_sel_q  <= cmd_byte_sel;
            trunc_q     <= cmd_trunc;
            wl_addr     <= cmd_addr;
            proj_sel    <= cmd_proj;
            array_din   <= cmd_wdata;
            state       <= ST_PRECHG;
          end
        end
        ST_PRECHG: begin
          if (phase_done) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (phase_done) begin
            rsp_rdata <= we_q ? '0 : shaped;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign precharge = (state == ST_PRECHG);
  assign wl_en     = (state == ST_ACCESS);
  assign read_en   = (state == ST_ACCESS) && !we_q;
  assign din_en    = (state == ST_ACCESS) && we_q;
  assign write_en  = din_en ? lane_mask : '0;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign done_irq  = rsp_valid && rsp_ready;

`ifdef IMPACT_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (done_irq) begin
      if (we_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_impact_array_sequencer.sv
// Self-checking bench for impact_array_sequencer (DATA_W=16, default phase lengths).
`timescale 1ns/1ps
module tb_impact_array_sequencer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int N_PROJ = 4;
  localparam int P      = 2;
  localparam int A      = 2;
  localparam int NL     = 2;
  localparam int PSEL_W = 2;
  localparam int BSEL_W = 1;
  localparam logic [DATA_W-1:0] LANE_MASK = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] NIB_MASK  = DATA_W'(8'h0F);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [PSEL_W-1:0] cmd_proj = '0;
  logic              cmd_byte_mode = 1'b0;
  logic [BSEL_W-1:0] cmd_byte_sel = '0;
  logic              cmd_trunc = 1'b0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              precharge;
  logic              wl_en;
  logic [ADDR_W-1:0] wl_addr;
  logic              read_en;
  logic [NL-1:0]     write_en;
  logic              din_en;
  logic [PSEL_W-1:0] proj_sel;
  logic [DATA_W-1:0] array_din;
  logic [DATA_W-1:0] array_dout = '0;
  logic              busy;
  logic              done_irq;
`ifdef IMPACT_SEQ_PERF_EN
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;
  int                rd_m = 0;
  int                wr_m = 0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_accept = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  impact_array_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_PROJ(N_PROJ), .PRECHG_CYC(P), .ACC_CYC(A)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_proj(cmd_proj), .cmd_byte_mode(cmd_byte_mode), .cmd_byte_sel(cmd_byte_sel),
    .cmd_trunc(cmd_trunc), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .precharge(precharge), .wl_en(wl_en), .wl_addr(wl_addr), .read_en(read_en),
    .write_en(write_en), .din_en(din_en), .proj_sel(proj_sel), .array_din(array_din),
    .array_dout(array_dout), .busy(busy), .done_irq(done_irq)
`ifdef IMPACT_SEQ_PERF_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  // Reference: pick the lane by shifting, then clear the high nibble of every byte.
  function automatic logic [DATA_W-1:0] model_rdata(logic [DATA_W-1:0] dout, bit bm, int sel, bit tr);
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] m;
    if (!bm) v = dout;
    else if (sel < NL) v = (dout >> (8 * sel)) & LANE_MASK;
    else v = '0;
    if (tr) begin
      m = '0;
      for (int i = 0; i < NL; i++) m = (m << 8) | NIB_MASK;
      v = v & m;
    end
    return v;
  endfunction

  function automatic logic [NL-1:0] model_wen(bit bm, int sel);
    if (!bm) return '1;
    if (sel >= NL) return '0;
    return NL'(1) << sel;
  endfunction

  function automatic logic [9:0] strobes();
    return {precharge, wl_en, read_en, din_en, write_en, rsp_valid, cmd_ready, busy, done_irq};
  endfunction

  task automatic scramble_cmd();
    cmd_valid     = 1'($urandom_range(0, 1));
    cmd_we        = 1'($urandom_range(0, 1));
    cmd_addr      = ADDR_W'($urandom);
    cmd_proj      = PSEL_W'($urandom);
    cmd_byte_mode = 1'($urandom_range(0, 1));
    cmd_byte_sel  = BSEL_W'($urandom);
    cmd_trunc     = 1'($urandom_range(0, 1));
    cmd_wdata     = DATA_W'($urandom);
  endtask

  // Starts at a negedge; ends at the negedge after the response handshake.
  task automatic do_cmd(input string name, input bit we, input int addr, input int proj,
                        input bit bm, input int sel, input bit tr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] dout,
                        input int hold);
    logic [DATA_W-1:0] exp_rd;
    logic [NL-1:0]     exp_wen;
    logic [NL-1:0]     wen_now;
    logic [9:0]        exp_vec;
    int n;
    exp_rd  = we ? '0 : model_rdata(dout, bm, sel, tr);
    exp_wen = model_wen(bm, sel);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = ADDR_W'(addr); cmd_proj = PSEL_W'(proj);
    cmd_byte_mode = bm; cmd_byte_sel = BSEL_W'(sel); cmd_trunc = tr; cmd_wdata = wdata;
    array_dout = dout;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL %s accept: cmd_ready=0 after %0d cycles, required 1", name, n);
      cmd_valid = 1'b0;
      return;
    end
    last_accept = cyc;
    @(negedge clk);
    for (int c = 1; c <= P + A; c++) begin
      scramble_cmd();
      wen_now = (c > P && we) ? exp_wen : '0;
      exp_vec = {c <= P, c > P, c > P && !we, c > P && we, wen_now, 1'b0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (strobes() !== exp_vec) begin
        errors++;
        $display("FAIL %s strobes cycle %0d: got %b, required %b", name, c, strobes(), exp_vec);
      end
      checks++;
      if ({wl_addr, proj_sel, array_din} !== {ADDR_W'(addr), PSEL_W'(proj), wdata}) begin
        errors++;
        $display("FAIL %s latched cycle %0d: addr=%h proj=%h din=%h, required %h %h %h",
                 name, c, wl_addr, proj_sel, array_din, addr, proj, wdata);
      end
      @(negedge clk);
    end
    for (int h = 0; h < hold; h++) begin
      array_dout = DATA_W'($urandom);
      cmd_valid  = 1'($urandom_range(0, 1));
      checks++;
      if ({strobes(), rsp_rdata} !== {10'b0000_00_1010, exp_rd}) begin
        errors++;
        $display("FAIL %s hold %0d: strobes=%b rdata=%h, required 0000001010 %h",
                 name, h, strobes(), rsp_rdata, exp_rd);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, done_irq, cmd_ready, rsp_rdata} !== {3'b110, exp_rd}) begin
      errors++;
      $display("FAIL %s response: valid=%b irq=%b ready=%b rdata=%h, required 1 1 0 %h",
               name, rsp_valid, done_irq, cmd_ready, rsp_rdata, exp_rd);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
`ifdef IMPACT_SEQ_PERF_EN
    if (we) wr_m = (wr_m < 65535) ? wr_m + 1 : wr_m;
    else rd_m = (rd_m < 65535) ? rd_m + 1 : rd_m;
`endif
    checks++;
    if ({rsp_valid, done_irq, cmd_ready, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL %s release: valid=%b irq=%b ready=%b busy=%b, required 0 0 1 0",
               name, rsp_valid, done_irq, cmd_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({strobes(), wl_addr, proj_sel, array_din, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: strobes=%b addr=%h proj=%h din=%h rdata=%h, required all 0",
               strobes(), wl_addr, proj_sel, array_din, rsp_rdata);
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, required 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_cycle_ready: got %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_directed();
    do_cmd("read_word", 1'b0, 3, 1, 1'b0, 0, 1'b0, 16'h7E7E, 16'hA5C3, 0);
    do_cmd("write_byte", 1'b1, 9, 2, 1'b1, 1, 1'b0, 16'h1234, 16'hFFFF, 0);
    do_cmd("read_byte_trunc", 1'b0, 5, 3, 1'b1, 1, 1'b1, 16'h0000, 16'hA5C3, 0);
    do_cmd("read_lane0_trunc", 1'b0, 0, 0, 1'b1, 0, 1'b1, 16'h0000, 16'hA5C3, 0);
    do_cmd("write_word", 1'b1, 15, 3, 1'b0, 0, 1'b0, 16'hBEEF, 16'h0000, 0);
  endtask

  task automatic test_hold();
    do_cmd("hold_read", 1'b0, 6, 1, 1'b0, 0, 1'b1, 16'h0000, 16'h5AF0, 3);
  endtask

  task automatic test_back_to_back();
    int a1;
    do_cmd("b2b_first", 1'b0, 1, 0, 1'b0, 0, 1'b0, 16'h0000, 16'h1357, 0);
    a1 = last_accept;
    do_cmd("b2b_second", 1'b1, 2, 1, 1'b1, 0, 1'b0, 16'h2468, 16'h0000, 0);
    checks++;
    if (last_accept - a1 !== P + A + 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles, required %0d", last_accept - a1, P + A + 2);
    end
  endtask

  task automatic test_abort_reset();
    int n;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'h4; cmd_proj = 2'd1;
    cmd_byte_mode = 1'b0; cmd_trunc = 1'b0; array_dout = 16'hCAFE;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (P) @(negedge clk);
    checks++;
    if ({wl_en, read_en} !== 2'b11) begin
      errors++;
      $display("FAIL abort_in_access: wl_en/read_en=%b, required 11", {wl_en, read_en});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (strobes() !== '0) begin
      errors++;
      $display("FAIL abort_async_drop: strobes=%b, required 0", strobes());
    end
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
`ifdef IMPACT_SEQ_PERF_EN
    rd_m = 0;
    wr_m = 0;
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, done_irq, busy} !== 3'b000) begin
        errors++;
        $display("FAIL abort_no_response cycle %0d: valid/irq/busy=%b, required 000",
                 i, {rsp_valid, done_irq, busy});
      end
    end
    rsp_ready = 1'b0;
    do_cmd("after_abort", 1'b0, 7, 2, 1'b0, 0, 1'b0, 16'h0000, 16'h0F1E, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      do_cmd("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, NL - 1)), 1'($urandom_range(0, 1)),
             DATA_W'($urandom), DATA_W'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

`ifdef IMPACT_SEQ_PERF_EN
  task automatic test_perf();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rd_m = 0;
    wr_m = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      do_cmd("perf_rd", 1'b0, i, 0, 1'b0, 0, 1'b0, 16'h0, DATA_W'($urandom), 0);
    for (int i = 0; i < 2; i++)
      do_cmd("perf_wr", 1'b1, i, 1, 1'b0, 0, 1'b0, DATA_W'($urandom), 16'h0, 0);
    checks++;
    if ({rd_count, wr_count} !== {16'(rd_m), 16'(wr_m)} || rd_m != 3 || wr_m != 2) begin
      errors++;
      $display("FAIL perf_counts: rd=%0d wr=%0d, required 3 2", rd_count, wr_count);
    end
    force dut.wr_count = 16'hFFFF;
    @(negedge clk);
    release dut.wr_count;
    wr_m = 65535;
    do_cmd("perf_sat", 1'b1, 3, 2, 1'b0, 0, 1'b0, 16'h55AA, 16'h0, 0);
    checks++;
    if (wr_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL perf_saturate: wr=%h, required ffff", wr_count);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_abort_reset();
    test_random();
`ifdef IMPACT_SEQ_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/impact_array_sequencer.md
Name: impact_array_sequencer

Overview:
- Parametrised successor to the IMPACT head array controller.
- Replaces pin-level PreCharge/WL/Read/Write/DataIn strobing driven directly from io_in with an on-chip sequencer.
- Accepts one command per valid/ready handshake and generates timed precharge → wordline+access phases for the selected project array.
- Returns read data (byte-select/truncate applied) through a valid/ready response channel; generalised in data width, address depth, project count and phase lengths.

Parameters:
- DATA_W, 8, array data width; multiple of 8; lanes NL = DATA_W/8.
- ADDR_W, 4, wordline address width (2**ADDR_W rows).
- N_PROJ, 4, number of project arrays; PSEL_W = max(1, clog2(N_PROJ)).
- PRECHG_CYC, 2, precharge phase length in cycles; must be ≥1.
- ACC_CYC, 2, wordline/access phase length in cycles; must be ≥1.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  row address.
- cmd_proj  in  PSEL_W  project select.
- cmd_byte_mode  in  1  single-lane access.
- cmd_byte_sel  in  max(1,clog2(NL))  lane index when byte_mode.
- cmd_trunc  in  1  truncate read bytes to low nibble.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accept.
- rsp_rdata  out  DATA_W  read result; 0 for writes.
- precharge  out  1  bitline precharge strobe.
- wl_en  out  1  wordline enable.
- wl_addr  out  ADDR_W  latched row.
- read_en  out  1  sense enable.
- write_en  out  NL  per-lane write enable.
- din_en  out  1  write driver enable.
- proj_sel  out  PSEL_W  latched project.
- array_din  out  DATA_W  latched write data.
- array_dout  in  DATA_W  sensed array data.
- busy  out  1  high whenever state != IDLE.
- done_irq  out  1  one-cycle pulse on response handshake.

Behaviour:
- Reset (rst=0, async): state=IDLE; every output 0, including latched wl_addr/proj_sel/array_din/rsp_rdata. cmd_ready rises the first cycle after reset release.
- FSM states: IDLE, PRECHG, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch all cmd_* fields and go to PRECHG.
  - cmd_ready=0 in every other state.
- PRECHG:
  - precharge=1 for exactly PRECHG_CYC cycles (down-counter), then ACCESS.
  - wl_en, read_en and write_en are never high together with precharge.
- ACCESS, for ACC_CYC cycles:
  - wl_en=1.
  - Read: read_en=1. On the last ACCESS cycle, register array_dout into rsp_rdata.
  - Write: din_en=1. write_en = all ones if byte_mode=0, else one-hot lane byte_sel. byte_sel ≥ NL masks to 0 (no write, response still returned).
  - Then go to RESP.
- Read data shaping, applied at capture:
  - byte_mode=1: rsp_rdata[7:0] = selected lane; upper bits 0.
  - trunc=1: bits [7:4] of every returned byte forced to 0.
- RESP:
  - rsp_valid=1 and held stable until rsp_ready.
  - On the handshake: done_irq pulses for 1 cycle, state goes to IDLE; no new accept in the same cycle.
- Latency: accept at cycle 0 → rsp_valid at cycle PRECHG_CYC+ACC_CYC+1 (5 with defaults). Minimum command spacing is PRECHG_CYC+ACC_CYC+2 cycles.
- Outputs are latched at accept; cmd_* changes after accept have no effect.
- Reset mid-operation: strobes drop immediately; no response is issued for the aborted command.
- cmd_valid while busy is ignored (not queued).

Optional Feature:
- Macro: IMPACT_SEQ_PERF_EN.
- Defined: adds outputs rd_count and wr_count (16 bits each). Each increments on the response handshake of its op type, saturates at 0xFFFF, and clears only on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package impact_pkg holds the FSM state enum (seq_state_t) and the localparam helpers for NL and PSEL_W.
- One sub-module, impact_phase_timer: loadable down-counter with a done flag, instantiated once and reloaded per phase.

Test Plan:
- Read, DATA_W=16, array_dout=0xA5C3, byte_mode=0 → precharge high cycles 1-2, wl_en+read_en cycles 3-4, rsp_valid cycle 5, rsp_rdata=0xA5C3.
- Write, byte_mode=1, byte_sel=1, wdata=0x1234, addr=0x9, proj=2 → write_en=2'b10 and din_en during ACCESS; wl_addr=9, proj_sel=2, array_din=0x1234; rsp_rdata=0.
- Read, byte_mode=1, byte_sel=1, trunc=1, array_dout=0xA5C3 → rsp_rdata=0x0005.
- Hold rsp_ready=0 for 3 cycles → rsp_valid/rsp_rdata stable, cmd_ready=0; on ready: done_irq 1 cycle, cmd_ready=1 next cycle.
- Assert rst=0 during ACCESS → all strobes 0 asynchronously, no rsp_valid after release, next command completes normally.
- With IMPACT_SEQ_PERF_EN: 3 reads + 2 writes → rd_count=3, wr_count=2; preload wr_count to 0xFFFF → stays 0xFFFF after a write.
